hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Backward-direction control for the 5-stage pipeline. Watches register
//  addresses and control bits held in the IF/ID, ID/EX, EX/MEM and MEM/WB
//  pipeline registers, and returns stall, flush and forward selects to them.
//  Detects load-use, branch-compare and data-memory-wait hazards.
//  Tracks the active hazard in a registered FSM, with a saturating stall
//  counter and a memory-wait timeout.
// PARAMETERS
//  CNT_W        16  width of the stall_cycles performance counter
//  WAIT_W        8  width of the memory-wait counter
//  MEM_TIMEOUT  64  consecutive MEM_WAIT cycles that set mem_timeout (<2**WAIT_W)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  rs_d, rt_d    in   5      source regs of instruction in ID
//  branch_d      in   1      ID instruction is a branch (compared in ID)
//  rs_e, rt_e    in   5      source regs in EX
//  writereg_e    in   5      destination reg in EX
//  regwrite_e    in   1      EX writes register file
//  memtoreg_e    in   1      EX is a load
//  writereg_m    in   5      destination reg in MEM
//  regwrite_m    in   1      MEM writes register file
//  memtoreg_m    in   1      MEM is a load
//  mem_req_m     in   1      MEM accesses data memory (load or store)
//  mem_ready     in   1      data memory completes the access this cycle
//  writereg_w    in   5      destination reg in WB
//  regwrite_w    in   1      WB writes register file
//  stall_f       out  1      hold PC
//  stall_d       out  1      hold IF/ID register
//  stall_e       out  1      hold ID/EX register
//  stall_m       out  1      hold EX/MEM register
//  flush_e       out  1      load bubble (all controls 0) into ID/EX
//  flush_w       out  1      load bubble into MEM/WB
//  forward_ad    out  1      ID comparator A takes EX/MEM aluout
//  forward_bd    out  1      ID comparator B takes EX/MEM aluout
//  forward_ae    out  2      EX srcA: 00 regfile, 01 WB result, 10 EX/MEM aluout
//  forward_be    out  2      EX srcB: same encoding as forward_ae
//  hazard_state  out  2      registered FSM state
//  stall_cycles  out  CNT_W  saturating count of cycles with stall_f=1
//  mem_timeout   out  1      sticky error flag
// BEHAVIOUR
//  Reset: state=RUN(00), counters 0, mem_timeout 0.
//  While reset is high: all stall/flush/forward outputs are 0, except flush_e=1.
//  Register 0 never matches in any comparison below.
//  Forwarding (combinational):
//   forward_ae=10 if rs_e==writereg_m&&regwrite_m;
//    else 01 if rs_e==writereg_w&&regwrite_w; else 00. MEM has priority.
//   forward_be: same rule, using rt_e.
//   forward_ad=(rs_d==writereg_m)&&regwrite_m; forward_bd same rule, using rt_d.
//  Hazard terms (combinational):
//   memwait = mem_req_m && !mem_ready
//   lwstall = memtoreg_e && (rt_e==rs_d || rt_e==rt_d)
//   brstall = branch_d && ((regwrite_e && writereg_e in {rs_d,rt_d})
//             || (memtoreg_m && writereg_m in {rs_d,rt_d}))
//  Priority: memwait > lwstall > brstall. Only one hazard is serviced per cycle.
//   memwait:          stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_e=0
//   lwstall/brstall:  stall_f=stall_d=1, flush_e=1, stall_e=stall_m=flush_w=0
//   none:             all stall/flush outputs 0
//  FSM (registered at each clk edge from the next-cycle terms):
//   RUN(00), LOAD_STALL(01), BRANCH_STALL(10), MEM_WAIT(11).
//   Next state is the highest-priority active term; RUN if no term is active.
//   Any state can move to any other state in one cycle.
//  Outputs are combinational from current inputs, not from state: zero latency.
//  wait_cnt:
//   Increments on each edge where next state is MEM_WAIT; cleared otherwise.
//   Saturates at 2**WAIT_W-1.
//  mem_timeout:
//   Set on the edge where wait_cnt becomes MEM_TIMEOUT.
//   Stays set until reset, even after mem_ready.
//  stall_cycles:
//   +1 on every edge where stall_f=1; holds at 2**CNT_W-1, no wrap.
//  Reset mid-stall: FSM goes to RUN immediately (async); counters clear.
//  Outputs follow the reset values above.
// TESTING
//  1 rs_e=5, writereg_m=5, regwrite_m=1, writereg_w=5, regwrite_w=1
//    -> forward_ae=10; then regwrite_m=0 -> 01; then rs_e=0 -> 00.
//  2 Load-use: memtoreg_e=1, rt_e=8, rs_d=8 for 1 cycle
//    -> stall_f=stall_d=flush_e=1; hazard_state=01 next cycle; stall_cycles=1.
//  3 Branch: branch_d=1, rs_d=3, regwrite_e=1, writereg_e=3
//    -> brstall asserted; state=10. Then writereg_m=3, memtoreg_m=0, regwrite_m=1
//    -> no stall, forward_ad=1.
//  4 mem_req_m=1, mem_ready=0 held 3 cycles, lwstall also true
//    -> 4 stalls=1, flush_w=1, flush_e=0, state=11. mem_ready=1 -> state=01.
//  5 mem_ready=0 held 64 cycles (MEM_TIMEOUT=64)
//    -> mem_timeout rises on 64th edge, stays 1 after mem_ready.
//    Assert reset -> mem_timeout=0.
//  6 CNT_W=4, 20 continuous lwstall cycles -> stall_cycles holds at 15.
//    Reset asserted mid-stall -> outputs and state at reset values same cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Backward-direction hazard control for the 5-stage pipeline: forwarding selects,
// stall/flush generation, a registered hazard-state FSM and stall/wait counters.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             branch_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       writereg_e,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic [4:0]       writereg_m,
    input  logic             regwrite_m,
    input  logic             memtoreg_m,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic [4:0]       writereg_w,
    input  logic             regwrite_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_e,
    output logic             flush_w,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN          = 2'b00,
        LOAD_STALL   = 2'b01,
        BRANCH_STALL = 2'b10,
        MEM_WAIT     = 2'b11
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              memwait;
    logic              lwstall;
    logic              brstall;

    // $zero is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    assign memwait = mem_req_m && !mem_ready;
    assign lwstall = memtoreg_e && (reg_match(rt_e, rs_d) || reg_match(rt_e, rt_d));
    assign brstall = branch_d &&
                     ((regwrite_e && (reg_match(writereg_e, rs_d) || reg_match(writereg_e, rt_d))) ||
                      (memtoreg_m && (reg_match(writereg_m, rs_d) || reg_match(writereg_m, rt_d))));

    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        forward_ad = 1'b0;
        forward_bd = 1'b0;
        if (!reset) begin
            if (regwrite_m && reg_match(rs_e, writereg_m))
                forward_ae = 2'b10;
            else if (regwrite_w && reg_match(rs_e, writereg_w))
                forward_ae = 2'b01;
            if (regwrite_m && reg_match(rt_e, writereg_m))
                forward_be = 2'b10;
            else if (regwrite_w && reg_match(rt_e, writereg_w))
                forward_be = 2'b01;
            forward_ad = regwrite_m && reg_match(rs_d, writereg_m);
            forward_bd = regwrite_m && reg_match(rt_d, writereg_m);
        end
    end

    // Only the highest-priority hazard drives the stall/flush pattern.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_e    = 1'b0;
        flush_w    = 1'b0;
        state_next = RUN;
        if (reset) begin
            flush_e = 1'b1;
        end else if (memwait) begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            stall_e    = 1'b1;
            stall_m    = 1'b1;
            flush_w    = 1'b1;
            state_next = MEM_WAIT;
        end else if (lwstall || brstall) begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            flush_e    = 1'b1;
            state_next = lwstall ? LOAD_STALL : BRANCH_STALL;
        end
    end

    assign wait_inc     = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_ONE;
    assign hazard_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if (state_next == MEM_WAIT) begin
                wait_cnt <= wait_inc;
                if (wait_inc == TIMEOUT_VAL)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (stall_f && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule
